hmc_rsp_link_sched: RTL and testbench

HMC_RSP_LINK_SCHED -- requirements
Module: hmc_rsp_link_sched

---
 rtl/hmc_rsp_link_sched_if.sv | 37 +++
 rtl/hmc_rsp_link_sched.sv | 128 ++++++++++++
 tb/tb_hmc_rsp_link_sched.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmc_rsp_link_sched_if.sv
// Handshake bundle between the vault response requesters / HMC link and the
// response link scheduler. The master side drives requests and link status.
interface hmc_rsp_link_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*4-1:0]   req_len;
    logic [NUM_REQ*128-1:0] req_flit;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_valid;
    logic [127:0]           tx_flit;
    logic                   tx_ready;
    logic                   token_ret_valid;
    logic [4:0]             token_ret_cnt;
    logic                   link_active;
    logic [7:0]             tokens_avail;
    logic [GW-1:0]          grant_id;
    logic                   busy;
    logic                   token_err;
    logic                   len_err;

    modport master (
        output req_valid, req_len, req_flit, tx_ready,
               token_ret_valid, token_ret_cnt, link_active,
        input  req_ready, tx_valid, tx_flit, tokens_avail,
               grant_id, busy, token_err, len_err
    );

    modport slave (
        input  req_valid, req_len, req_flit, tx_ready,
               token_ret_valid, token_ret_cnt, link_active,
        output req_ready, tx_valid, tx_flit, tokens_avail,
               grant_id, busy, token_err, len_err
    );
endinterface

// File: rtl/hmc_rsp_link_sched.sv
// Token-gated round-robin scheduler of vault response packets onto one link TX
// FLIT path. Define HMC_SCHED_PRIO_EN to give requester 0 strict priority.
module hmc_rsp_link_sched #(
    parameter int NUM_REQ     = 4,
    parameter int INIT_TOKENS = 64
) (
    input logic                 clk,
    input logic                 reset,
    hmc_rsp_link_sched_if.slave bus
);
    localparam int         GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TOK_INIT = 8'(INIT_TOKENS);
`ifdef HMC_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
    state_t state, state_nxt;

    logic [GW-1:0]      grant_id, rr_ptr, win, scan_idx;
    logic [3:0]         len_q, flit_cnt;
    logic [7:0]         tokens, tok_nxt;
    logic [8:0]         tok_sum;
    logic               token_err, len_err, grant, tok_ovf, hs, last_flit, xfer;
    logic [NUM_REQ-1:0] eligible, len_bad;
    logic [3:0]         len_arr  [NUM_REQ];
    logic [127:0]       flit_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_arr[i]  = bus.req_len[i*4 +: 4];
            flit_arr[i] = bus.req_flit[i*128 +: 128];
            len_bad[i]  = bus.req_valid[i] && (len_arr[i] == 4'd0 || len_arr[i] > 4'd9);
            eligible[i] = bus.req_valid[i] && !len_bad[i] && bus.link_active
                          && ({4'd0, len_arr[i]} <= tokens);
        end
    end

    // Scan farthest-to-nearest so the requester closest to rr_ptr wins last.
    always_comb begin
        grant    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
            if (eligible[scan_idx] && !(PRIO && scan_idx == '0)) begin
                grant = 1'b1;
                win   = scan_idx;
            end
        end
        if (PRIO && eligible[0]) begin
            grant = 1'b1;
            win   = '0;
        end
    end

    // Deduction cannot underflow: a grant needs len <= tokens.
    always_comb begin
        tok_sum = {1'b0, tokens};
        if (state == IDLE && grant) tok_sum = tok_sum - {5'd0, len_arr[win]};
        if (bus.token_ret_valid)    tok_sum = tok_sum + {4'd0, bus.token_ret_cnt};
        tok_ovf = (tok_sum > 9'(INIT_TOKENS));
        tok_nxt = tok_ovf ? TOK_INIT : tok_sum[7:0];
    end

    assign xfer      = (state == XFER) && !reset;
    assign hs        = bus.tx_valid && bus.tx_ready;
    assign last_flit = ((flit_cnt + 4'd1) == len_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = XFER;
            XFER:    if (hs && last_flit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = xfer;
        bus.tx_valid  = 1'b0;
        bus.tx_flit   = flit_arr[grant_id];
        bus.req_ready = '0;
        if (xfer) begin
            bus.tx_valid            = bus.req_valid[grant_id];
            bus.req_ready[grant_id] = bus.tx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            len_q     <= 4'd0;
            flit_cnt  <= 4'd0;
            tokens    <= TOK_INIT;
            token_err <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            tokens <= tok_nxt;
            if (tok_ovf) token_err <= 1'b1;
            if (state == IDLE) begin
                if (|len_bad) len_err <= 1'b1;
                if (grant) begin
                    grant_id <= win;
                    len_q    <= len_arr[win];
                    flit_cnt <= 4'd0;
                    // Under priority, requester 0 wins do not disturb the others' rotation.
                    if (!(PRIO && win == '0)) rr_ptr <= GW'((int'(win) + 1) % NUM_REQ);
                end
            end else if (hs) begin
                flit_cnt <= last_flit ? 4'd0 : flit_cnt + 4'd1;
            end
        end
    end

    assign bus.tokens_avail = tokens;
    assign bus.grant_id     = grant_id;
    assign bus.token_err    = token_err;
    assign bus.len_err      = len_err;
endmodule

// File: tb/tb_hmc_rsp_link_sched.sv
// Self-checking bench for hmc_rsp_link_sched: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_hmc_rsp_link_sched;
    localparam int N    = 4;
    localparam int INIT = 64;
`ifdef HMC_SCHED_PRIO_EN
    localparam bit PRIO_TB = 1'b1;
`else
    localparam bit PRIO_TB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hmc_rsp_link_sched_if #(.NUM_REQ(N)) bus ();
    hmc_rsp_link_sched #(.NUM_REQ(N), .INIT_TOKENS(INIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [N-1:0] vld;
    logic [3:0]   len  [N];
    logic [127:0] flit [N];

    always_comb begin
        bus.req_valid = vld;
        bus.req_len   = '0;
        bus.req_flit  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_len[i*4 +: 4]      = len[i];
            bus.req_flit[i*128 +: 128] = flit[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        vld = '0;
        for (int i = 0; i < N; i++) begin
            len[i]  = 4'd1;
            flit[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.tx_ready        = 1'b1;
        bus.token_ret_valid = 1'b0;
        bus.token_ret_cnt   = 5'd0;
        bus.link_active     = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        vld   = '1;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_during_txvalid got=%0b exp=0", bus.tx_valid); end
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_during_ready got=%0b exp=0", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_during_busy got=%0b exp=0", bus.busy); end
        next_cycle();
        reset = 1'b0;
        vld   = '0;
        @(negedge clk);
        checks++; if (bus.tokens_avail !== 8'(INIT)) begin errors++; $display("FAIL rst_tokens got=%0d exp=%0d", bus.tokens_avail, INIT); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id got=%0d exp=0", bus.grant_id); end
        checks++; if (bus.token_err !== 1'b0 || bus.len_err !== 1'b0) begin errors++; $display("FAIL rst_errs got=%0b%0b exp=00", bus.token_err, bus.len_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_rr_len1();
        int g;
        do_reset();
        vld = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            g = (c / 2) % N;
            checks++; if (bus.busy !== 1'(c % 2)) begin errors++; $display("FAIL rr_busy c=%0d got=%0b exp=%0b", c, bus.busy, c % 2); end
            if (c % 2 == 1) begin
                checks++; if (bus.grant_id !== 2'(g)) begin errors++; $display("FAIL rr_grant c=%0d got=%0d exp=%0d", c, bus.grant_id, g); end
                checks++; if (bus.tx_valid !== 1'b1 || bus.tx_flit !== flit[g]) begin errors++; $display("FAIL rr_flit c=%0d got=%0h exp=%0h", c, bus.tx_flit, flit[g]); end
            end
            checks++; if (bus.tokens_avail !== 8'(INIT - (c + 1) / 2)) begin errors++; $display("FAIL rr_tokens c=%0d got=%0d exp=%0d", c, bus.tokens_avail, INIT - (c + 1) / 2); end
            next_cycle();
        end
        vld = '0;
    endtask

    task automatic test_token_starve();
        bit done = 1'b0;
        do_reset();
        vld[1] = 1'b1;
        len[1] = 4'd9;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.tokens_avail == 8'd1 && bus.busy == 1'b0) done = 1'b1;
            else next_cycle();
        end
        checks++; if (!done) begin errors++; $display("FAIL starve_drain tokens=%0d exp=1 within 200 cycles", bus.tokens_avail); end
        next_cycle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_no_grant got=%0b exp=0", bus.busy); end
        vld[0] = 1'b1;
        len[0] = 4'd9;
        len[1] = 4'd1;
        next_cycle();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL starve_req1 busy=%0b grant=%0d exp 1/1", bus.busy, bus.grant_id); end
        checks++; if (bus.tokens_avail !== 8'd0) begin errors++; $display("FAIL starve_tok0 got=%0d exp=0", bus.tokens_avail); end
        next_cycle();
        vld[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.busy !== 1'b0 || bus.tokens_avail !== 8'd0) begin errors++; $display("FAIL starve_hold c=%0d busy=%0b tok=%0d exp 0/0", c, bus.busy, bus.tokens_avail); end
            next_cycle();
        end
        bus.token_ret_valid = 1'b1;
        bus.token_ret_cnt   = 5'd9;
        next_cycle();
        bus.token_ret_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.tokens_avail !== 8'd9 || bus.busy !== 1'b0) begin errors++; $display("FAIL starve_ret tok=%0d busy=%0b exp 9/0", bus.tokens_avail, bus.busy); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0 || bus.tokens_avail !== 8'd0) begin errors++; $display("FAIL starve_req0 busy=%0b grant=%0d tok=%0d exp 1/0/0", bus.busy, bus.grant_id, bus.tokens_avail); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        do_reset();
        vld[2] = 1'b1;
        len[2] = 4'd5;
        for (int c = 0; c < 30; c++) begin
            bus.tx_ready = 1'(c % 2);
            flit[2] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (c == 0) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle got=%0b exp=0", bus.busy); end
            end else if (hs < 5) begin
                checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin errors++; $display("FAIL bp_busy c=%0d busy=%0b grant=%0d exp 1/2", c, bus.busy, bus.grant_id); end
                checks++; if (bus.tx_valid !== 1'b1 || bus.tx_flit !== flit[2]) begin errors++; $display("FAIL bp_flit c=%0d got=%0h exp=%0h", c, bus.tx_flit, flit[2]); end
                checks++; if (bus.req_ready !== (4'(bus.tx_ready) << 2)) begin errors++; $display("FAIL bp_ready c=%0d got=%0b", c, bus.req_ready); end
                if (bus.tx_valid && bus.tx_ready) hs++;
            end else begin
                checks++; if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL bp_after c=%0d busy=%0b txv=%0b exp 0/0", c, bus.busy, bus.tx_valid); end
            end
            next_cycle();
            if (hs == 5) vld[2] = 1'b0;
        end
        checks++; if (hs != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", hs); end
    endtask

    task automatic test_token_overflow();
        do_reset();
        bus.token_ret_valid = 1'b1;
        bus.token_ret_cnt   = 5'd10;
        next_cycle();
        bus.token_ret_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.tokens_avail !== 8'd64 || bus.token_err !== 1'b1) begin errors++; $display("FAIL ovf_clamp tok=%0d err=%0b exp 64/1", bus.tokens_avail, bus.token_err); end
        vld[3] = 1'b1;
        len[3] = 4'd4;
        bus.token_ret_valid = 1'b1;
        bus.token_ret_cnt   = 5'd3;
        next_cycle();
        bus.token_ret_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.tokens_avail !== 8'd63 || bus.grant_id !== 2'd3) begin errors++; $display("FAIL ovf_net tok=%0d grant=%0d exp 63/3", bus.tokens_avail, bus.grant_id); end
        repeat (4) next_cycle();
        vld = '0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.token_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky busy=%0b err=%0b exp 0/1", bus.busy, bus.token_err); end
        do_reset();
        @(negedge clk);
        checks++; if (bus.token_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", bus.token_err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        vld[1] = 1'b1;
        len[1] = 4'd4;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0 || bus.req_ready !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_during txv=%0b rdy=%0b busy=%0b exp 0", bus.tx_valid, bus.req_ready, bus.busy); end
        next_cycle();
        reset = 1'b0;
        vld   = '0;
        @(negedge clk);
        checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.tokens_avail !== 8'(INIT)) begin errors++; $display("FAIL midrst_after txv=%0b busy=%0b tok=%0d exp 0/0/64", bus.tx_valid, bus.busy, bus.tokens_avail); end
    endtask

    task automatic test_len_err();
        do_reset();
        vld[2] = 1'b1;
        len[2] = 4'd0;
        @(negedge clk);
        checks++; if (bus.len_err !== 1'b0) begin errors++; $display("FAIL lenerr_pre got=%0b exp=0", bus.len_err); end
        next_cycle();
        vld = '0;
        @(negedge clk);
        checks++; if (bus.len_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL lenerr_zero err=%0b busy=%0b exp 1/0", bus.len_err, bus.busy); end
        do_reset();
        vld[3] = 1'b1;
        len[3] = 4'd12;
        next_cycle();
        next_cycle();
        vld = '0;
        @(negedge clk);
        checks++; if (bus.len_err !== 1'b1 || bus.busy !== 1'b0 || bus.tokens_avail !== 8'(INIT)) begin errors++; $display("FAIL lenerr_big err=%0b busy=%0b tok=%0d exp 1/0/64", bus.len_err, bus.busy, bus.tokens_avail); end
    endtask

    task automatic test_prio();
        int e;
        do_reset();
        vld[0] = 1'b1;
        vld[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                e = PRIO_TB ? 0 : (((c / 2) % 2 == 0) ? 0 : 3);
                checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'(e)) begin errors++; $display("FAIL prio_grant c=%0d busy=%0b got=%0d exp=%0d", c, bus.busy, bus.grant_id, e); end
            end
            next_cycle();
        end
        vld = '0;
    endtask

    task automatic test_random();
        bit           m_busy, m_terr, m_lerr, found;
        int           m_gid, m_left, m_tok, m_start, ded, w, r;
        bit           el [N];
        logic [N-1:0] exp_ready;
        do_reset();
        m_busy = 0; m_terr = 0; m_lerr = 0;
        m_gid = 0; m_left = 0; m_tok = INIT; m_start = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) len[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
                else len[i] = 4'($urandom_range(1, 9));
                flit[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.tx_ready        = ($urandom_range(0, 3) != 0);
            bus.link_active     = ($urandom_range(0, 9) != 0);
            bus.token_ret_valid = ($urandom_range(0, 5) == 0);
            bus.token_ret_cnt   = 5'($urandom_range(0, 31));
            @(negedge clk);
            exp_ready = '0;
            if (m_busy) exp_ready[m_gid] = bus.tx_ready;
            checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, bus.busy, m_busy); end
            checks++; if (bus.tx_valid !== (m_busy && vld[m_gid])) begin errors++; $display("FAIL rnd_txvalid c=%0d got=%0b exp=%0b", c, bus.tx_valid, m_busy && vld[m_gid]); end
            checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, bus.req_ready, exp_ready); end
            checks++; if (bus.tokens_avail !== 8'(m_tok)) begin errors++; $display("FAIL rnd_tokens c=%0d got=%0d exp=%0d", c, bus.tokens_avail, m_tok); end
            checks++; if (bus.token_err !== m_terr || bus.len_err !== m_lerr) begin errors++; $display("FAIL rnd_errs c=%0d got=%0b%0b exp=%0b%0b", c, bus.token_err, bus.len_err, m_terr, m_lerr); end
            if (m_busy) begin
                checks++; if (bus.grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_grant c=%0d got=%0d exp=%0d", c, bus.grant_id, m_gid); end
                if (vld[m_gid]) begin
                    checks++; if (bus.tx_flit !== flit[m_gid]) begin errors++; $display("FAIL rnd_flit c=%0d got=%0h exp=%0h", c, bus.tx_flit, flit[m_gid]); end
                end
            end
            ded = 0;
            if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    if (vld[i] && (len[i] == 0 || len[i] > 9)) m_lerr = 1;
                    el[i] = vld[i] && len[i] >= 1 && len[i] <= 9 && int'(len[i]) <= m_tok && bus.link_active;
                end
                found = 0;
                w = 0;
                if (PRIO_TB && el[0]) begin found = 1; w = 0; end
                for (int k = 0; k < N; k++) begin
                    r = (m_start + k) % N;
                    if (!found && el[r] && !(PRIO_TB && r == 0)) begin found = 1; w = r; end
                end
                if (found) begin
                    m_busy = 1; m_gid = w; m_left = len[w]; ded = len[w];
                    if (!(PRIO_TB && w == 0)) m_start = (w + 1) % N;
                end
            end else if (vld[m_gid] && bus.tx_ready) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
            m_tok = m_tok - ded + (bus.token_ret_valid ? int'(bus.token_ret_cnt) : 0);
            if (m_tok > INIT) begin m_tok = INIT; m_terr = 1; end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rr_len1();
        test_token_starve();
        test_backpressure();
        test_token_overflow();
        test_reset_mid_packet();
        test_len_err();
        test_prio();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
